p2_decode_reg_read: RTL
=======================

// Module: p2_decode_reg_read
// PURPOSE
//  Phase-2 stage of the multi-cycle SIMPLE core. Decodes the 16-bit instruction register latched by
//  fetch (p1), reads the 8x16 register file into operand latches AR/BR and builds the immediate.
//  Owns the register file; performs register write-back in p5. Feeds execute (p3) and memory (p4).
// PARAMETERS
//  NREG     8    register count (address width 3; other values unsupported)
//  WIDTH    16   datapath width
// PORTS
//  clock          in   1   core clock; all state updates on negedge
//  reset          in   1   asynchronous, active-low; clears all state
//  phase_counter  in   3   000=p1 .. 100=p5
//  instruction    in   16  IR from fetch stage
//  wb_en          in   1   p5 register write enable (from execute/control)
//  wb_data        in   16  p5 write-back value
//  ar_out         out  16  operand A = rf[IR[13:11]] (Rs / Ra)
//  br_out         out  16  operand B = rf[IR[10:8]] (Rd / Rb)
//  imm_out        out  16  immediate, see BEHAVIOUR
//  wb_addr        out  3   destination register latched in p2
//  alu_op         out  4   IR[7:4] for class 11, 0000 (ADD) otherwise
//  op_mem_write   out  1   ST
//  op_mem_read    out  1   LD
//  op_reg_write   out  1   instruction writes a register in p5
//  op_branch_kind out  3   000 none, 001 B, 010 BE, 011 BLT, 100 BLE, 101 BNE
//  op_halt        out  1   HLT (class 11, op3=1111)
//  op_illegal     out  1   unassigned encoding
// BEHAVIOUR
//  - Reset (async, reset==0): all outputs and all 8 registers -> 0; op_branch_kind=000.
//  - Capture: at negedge with phase_counter==001, latch decode of instruction, AR, BR, imm, wb_addr.
//    Outputs hold unchanged through p3..p5 and until the next p2. Latency: IR stable in p2 -> outputs
//    valid after the p2 negedge (one edge).
//  - Decode by IR[15:14]:
//    11: ALU/IO; alu_op=IR[7:4]; wb_addr=IR[10:8]; imm=zero-ext IR[3:0] (shift amount);
//        op_reg_write=1 except op3 CMP(0101), OUT(1101), NOP(1110), HLT(1111); op3 1100 -> op_illegal.
//    00: LD; wb_addr=IR[13:11]; imm=sign-ext IR[7:0]; op_mem_read=1; op_reg_write=1.
//    01: ST; imm=sign-ext IR[7:0]; op_mem_write=1.
//    10: IR[13:11]=000 LI (wb_addr=IR[10:8], op_reg_write=1, imm=sign-ext IR[7:0]);
//        100 B; 111 conditional, IR[10:8] 000 BE, 001 BLT, 010 BLE, 011 BNE, others illegal;
//        branches imm=sign-ext IR[7:0]. Other IR[13:11] -> op_illegal.
//  - op_illegal forces op_reg_write=op_mem_write=op_mem_read=0, branch_kind=000.
//  - Write-back: at negedge with phase_counter==100 and wb_en==1, rf[wb_addr] <= wb_data.
//    Write in p5 never coincides with the p2 read; a value written in p5 is seen by the next p2.
//  - Phases 000, 010, 011, 101-111: no state change. Undefined phase codes are inert.
//  - Reset asserted mid-instruction: register file cleared immediately; pending write-back dropped.
// CONFIGURATION
//  DEBUG_RF_PORT_EN defined: adds ports dbg_sel (in, 3) and dbg_data (out, 16);
//    dbg_data = rf[dbg_sel] combinationally, for panel/7-seg display; no effect on core behaviour.
//  Not defined: ports absent, no extra read mux.
// TESTING
//  1 reset low mid-p3 -> all outputs 0, rf[0..7]==0 via debug port; release -> still 0.
//  2 p5 wb_en=1 wb_addr=3 data=0x1234; next p2 IR=0xD800 (ADD R3,R0) -> ar=0x1234, alu_op=0000,
//    op_reg_write=1, wb_addr=0.
//  3 p2 IR=0x0AFE (LD R1,-2(R2)) -> imm=0xFFFE, op_mem_read=1, wb_addr=1, br=rf[2].
//  4 p2 IR=0xBB05 (BNE +5) -> op_branch_kind=101, imm=0x0005, op_reg_write=0.
//  5 p2 IR=0xC0C0 (op3 1100) -> op_illegal=1, all enables 0; IR=0xC0F0 -> op_halt=1.
//  6 wb_en=1 outside p5 (phase 011) -> rf unchanged; IR change outside p2 -> outputs hold.

Source files
------------

// File: rtl/p2_decode_reg_read.sv
// Phase-2 decode/register-read stage of the SIMPLE core: owns the 8x16 register file, latches operands,
// immediate and control decode in p2, and performs write-back in p5. Optional DEBUG_RF_PORT_EN adds a debug read port.
module p2_decode_reg_read #(
   parameter int NREG  = 8,
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [2:0]       phase_counter,
   input  logic [15:0]      instruction,
   input  logic             wb_en,
   input  logic [WIDTH-1:0] wb_data,
   output logic [WIDTH-1:0] ar_out,
   output logic [WIDTH-1:0] br_out,
   output logic [WIDTH-1:0] imm_out,
   output logic [2:0]       wb_addr,
   output logic [3:0]       alu_op,
   output logic             op_mem_write,
   output logic             op_mem_read,
   output logic             op_reg_write,
   output logic [2:0]       op_branch_kind,
   output logic             op_halt,
   output logic             op_illegal
`ifdef DEBUG_RF_PORT_EN
   ,
   input  logic [2:0]       dbg_sel,
   output logic [WIDTH-1:0] dbg_data
`endif
);

   localparam logic [2:0] PH_P2 = 3'b001;
   localparam logic [2:0] PH_P5 = 3'b100;

   localparam logic [1:0] CLS_LD  = 2'b00;
   localparam logic [1:0] CLS_ST  = 2'b01;
   localparam logic [1:0] CLS_BR  = 2'b10;
   localparam logic [1:0] CLS_ALU = 2'b11;

   localparam logic [3:0] OP_CMP  = 4'b0101;
   localparam logic [3:0] OP_RSVD = 4'b1100;
   localparam logic [3:0] OP_OUT  = 4'b1101;
   localparam logic [3:0] OP_NOP  = 4'b1110;
   localparam logic [3:0] OP_HLT  = 4'b1111;

   localparam logic [2:0] SUB_LI   = 3'b000;
   localparam logic [2:0] SUB_B    = 3'b100;
   localparam logic [2:0] SUB_COND = 3'b111;

   localparam logic [2:0] BK_NONE = 3'b000;
   localparam logic [2:0] BK_B    = 3'b001;
   localparam logic [2:0] BK_BE   = 3'b010;
   localparam logic [2:0] BK_BLT  = 3'b011;
   localparam logic [2:0] BK_BLE  = 3'b100;
   localparam logic [2:0] BK_BNE  = 3'b101;

   logic [NREG-1:0][WIDTH-1:0] rf;

   logic [1:0]       ir_cls;
   logic [2:0]       ir_ra;
   logic [2:0]       ir_rb;
   logic [3:0]       ir_op3;
   logic [WIDTH-1:0] imm_sext;
   logic [WIDTH-1:0] imm_zext;

   logic [WIDTH-1:0] d_imm;
   logic [2:0]       d_wb_addr;
   logic [3:0]       d_alu_op;
   logic             d_mem_write;
   logic             d_mem_read;
   logic             d_reg_write;
   logic [2:0]       d_branch_kind;
   logic             d_halt;
   logic             d_illegal;

   assign ir_cls   = instruction[15:14];
   assign ir_ra    = instruction[13:11];
   assign ir_rb    = instruction[10:8];
   assign ir_op3   = instruction[7:4];
   assign imm_sext = {{(WIDTH-8){instruction[7]}}, instruction[7:0]};
   assign imm_zext = {{(WIDTH-4){1'b0}}, instruction[3:0]};

   always_comb begin
      d_imm         = '0;
      d_wb_addr     = '0;
      d_alu_op      = '0;
      d_mem_write   = 1'b0;
      d_mem_read    = 1'b0;
      d_reg_write   = 1'b0;
      d_branch_kind = BK_NONE;
      d_halt        = 1'b0;
      d_illegal     = 1'b0;

      case (ir_cls)
         CLS_ALU: begin
            d_alu_op  = ir_op3;
            d_wb_addr = ir_rb;
            d_imm     = imm_zext;
            case (ir_op3)
               OP_CMP, OP_OUT, OP_NOP: d_reg_write = 1'b0;
               OP_HLT:                 d_halt      = 1'b1;
               OP_RSVD:                d_illegal   = 1'b1;
               default:                d_reg_write = 1'b1;
            endcase
         end
         CLS_LD: begin
            d_wb_addr   = ir_ra;
            d_imm       = imm_sext;
            d_mem_read  = 1'b1;
            d_reg_write = 1'b1;
         end
         CLS_ST: begin
            d_imm       = imm_sext;
            d_mem_write = 1'b1;
         end
         default: begin
            d_imm = imm_sext;
            case (ir_ra)
               SUB_LI: begin
                  d_wb_addr   = ir_rb;
                  d_reg_write = 1'b1;
               end
               SUB_B: d_branch_kind = BK_B;
               SUB_COND: begin
                  case (ir_rb)
                     3'b000:  d_branch_kind = BK_BE;
                     3'b001:  d_branch_kind = BK_BLT;
                     3'b010:  d_branch_kind = BK_BLE;
                     3'b011:  d_branch_kind = BK_BNE;
                     default: d_illegal     = 1'b1;
                  endcase
               end
               default: d_illegal = 1'b1;
            endcase
         end
      endcase

      // An illegal encoding must not cause any side effect further down the pipe.
      if (d_illegal) begin
         d_reg_write   = 1'b0;
         d_mem_write   = 1'b0;
         d_mem_read    = 1'b0;
         d_branch_kind = BK_NONE;
      end
   end

   always_ff @(negedge clock or negedge reset) begin
      if (!reset) begin
         ar_out         <= '0;
         br_out         <= '0;
         imm_out        <= '0;
         wb_addr        <= '0;
         alu_op         <= '0;
         op_mem_write   <= 1'b0;
         op_mem_read    <= 1'b0;
         op_reg_write   <= 1'b0;
         op_branch_kind <= BK_NONE;
         op_halt        <= 1'b0;
         op_illegal     <= 1'b0;
      end else if (phase_counter == PH_P2) begin
         ar_out         <= rf[ir_ra];
         br_out         <= rf[ir_rb];
         imm_out        <= d_imm;
         wb_addr        <= d_wb_addr;
         alu_op         <= d_alu_op;
         op_mem_write   <= d_mem_write;
         op_mem_read    <= d_mem_read;
         op_reg_write   <= d_reg_write;
         op_branch_kind <= d_branch_kind;
         op_halt        <= d_halt;
         op_illegal     <= d_illegal;
      end
   end

   // p5 write-back uses the destination latched in p2; p2 and p5 never coincide.
   always_ff @(negedge clock or negedge reset) begin
      if (!reset) begin
         rf <= '0;
      end else if (phase_counter == PH_P5 && wb_en) begin
         rf[wb_addr] <= wb_data;
      end
   end

`ifdef DEBUG_RF_PORT_EN
   assign dbg_data = rf[dbg_sel];
`endif

endmodule
